hazard_flush_ctrl: RTL

//  Pipeline sequencer for the 5-stage RV32I core: detects load-use hazards, issues
//  F/D and D/E flushes on taken jumps/branches resolved in E, and freezes the whole

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_flush_ctrl_if.sv | 35 +++
 rtl/hz_mem_watchdog.sv | 94 +++++++++
 rtl/hazard_flush_ctrl.sv | 82 ++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared opcode constants, watchdog state encoding and register-use decode
// for the RV32I hazard/flush sequencer.
package hazard_pkg;

   localparam logic [4:0] OP_R      = 5'b01100;
   localparam logic [4:0] OP_OPIMM  = 5'b00100;
   localparam logic [4:0] OP_LOAD   = 5'b00000;
   localparam logic [4:0] OP_STORE  = 5'b01000;
   localparam logic [4:0] OP_BRANCH = 5'b11000;
   localparam logic [4:0] OP_JALR   = 5'b11001;
   localparam logic [4:0] OP_JAL    = 5'b11011;
   localparam logic [4:0] OP_LUI    = 5'b01101;
   localparam logic [4:0] OP_AUIPC  = 5'b00101;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } wd_state_e;

   function automatic logic use_rs1(input logic [4:0] op);
      return !((op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL));
   endfunction

   function automatic logic use_rs2(input logic [4:0] op);
      return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   function automatic logic is_mem_op(input logic [4:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// Pipeline-side bundle of the hazard sequencer: stage fields in, pipe controls
// and performance counters out. master = pipeline, slave = sequencer.
interface hazard_flush_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       D_op;
   logic [4:0]       D_rs1;
   logic [4:0]       D_rs2;
   logic [4:0]       E_op;
   logic [4:0]       E_rd;
   logic             E_b;
   logic [4:0]       M_op;
   logic             dm_ready;
   logic             stall;
   logic             pipe_hold;
   logic             FD_flush;
   logic             DE_flush;
   logic             next_pc_sel;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] hold_cnt;

   modport master (
      output D_op, D_rs1, D_rs2, E_op, E_rd, E_b, M_op, dm_ready,
      input  stall, pipe_hold, FD_flush, DE_flush, next_pc_sel, mem_err,
             stall_cnt, flush_cnt, hold_cnt
   );

   modport slave (
      input  D_op, D_rs1, D_rs2, E_op, E_rd, E_b, M_op, dm_ready,
      output stall, pipe_hold, FD_flush, DE_flush, next_pc_sel, mem_err,
             stall_cnt, flush_cnt, hold_cnt
   );
endinterface

// File: rtl/hz_mem_watchdog.sv
// Data-memory wait sequencer: freezes the pipe while M waits on dm_ready and
// bounds the wait. HAZARD_PERF_CNT_EN builds the WAIT-cycle counter.
//   state | meaning
//   RUN   | no outstanding wait; holds only on the first busy cycle
//   WAIT  | waiting for dm_ready, wcnt counts waited cycles
//   ERR   | timeout seen; one cycle, sets sticky mem_err
module hz_mem_watchdog
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_busy_i,
   input  logic             dm_ready_i,
   output logic             pipe_hold_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] hold_cnt_o
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   wd_state_e         state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              mem_err_q, mem_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         wcnt_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      mem_err_d   = mem_err_q;
      pipe_hold_o = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mem_busy_i) begin
               pipe_hold_o = 1'b1;
               state_d     = ST_WAIT;
               wcnt_d      = WCNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (dm_ready_i) begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_LAST) begin
               // hold drops here so the stalled access retires as if completed
               state_d = ST_ERR;
               wcnt_d  = '0;
            end else begin
               pipe_hold_o = 1'b1;
               wcnt_d      = wcnt_q + WCNT_W'(1);
            end
         end
         ST_ERR: begin
            mem_err_d = 1'b1;
            state_d   = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   assign mem_err_o = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] hold_cnt_q;

   // the cycle that sees dm_ready return is not a waited cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt_q <= '0;
      end else if ((state_q == ST_WAIT) && !dm_ready_i && (hold_cnt_q != '1)) begin
         hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      end
   end

   assign hold_cnt_o = hold_cnt_q;
`else
   assign hold_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Hazard/flush sequencer for the 5-stage RV32I pipe: load-use stall, E-stage
// redirect flush, memory-wait hold. HAZARD_PERF_CNT_EN builds the perf counters.
module hazard_flush_ctrl
   import hazard_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input logic                clk,
   input logic                rst,
   hazard_flush_ctrl_if.slave bus
);

   logic             lu_hz;
   logic             redir;
   logic             mem_busy;
   logic             pipe_hold;
   logic             redir_go;
   logic             stall_go;
   logic             mem_err;
   logic [CNT_W-1:0] hold_cnt;

   always_comb begin
      lu_hz = (bus.E_op == OP_LOAD) && (bus.E_rd != 5'd0) &&
              ((use_rs1(bus.D_op) && (bus.D_rs1 == bus.E_rd)) ||
               (use_rs2(bus.D_op) && (bus.D_rs2 == bus.E_rd)));
      redir = (bus.E_op == OP_JAL) || (bus.E_op == OP_JALR) ||
              ((bus.E_op == OP_BRANCH) && bus.E_b);
      mem_busy = is_mem_op(bus.M_op) && !bus.dm_ready;
   end

   hz_mem_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk         (clk),
      .rst         (rst),
      .mem_busy_i  (mem_busy),
      .dm_ready_i  (bus.dm_ready),
      .pipe_hold_o (pipe_hold),
      .mem_err_o   (mem_err),
      .hold_cnt_o  (hold_cnt)
   );

   // a held E stage keeps its redirect pending until the first released cycle
   assign redir_go = redir & ~pipe_hold;
   assign stall_go = lu_hz & ~pipe_hold;

   assign bus.pipe_hold   = pipe_hold;
   assign bus.stall       = stall_go;
   assign bus.FD_flush    = redir_go;
   assign bus.DE_flush    = redir_go;
   assign bus.next_pc_sel = ~redir_go;
   assign bus.mem_err     = mem_err;
   assign bus.hold_cnt    = hold_cnt;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_go && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (redir_go && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.stall_cnt = stall_cnt_q;
   assign bus.flush_cnt = flush_cnt_q;
`else
   assign bus.stall_cnt = {CNT_W{1'b0}};
   assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule
